// File: rtl/regfile_wr_demux.sv
// regfile_wr_demux: buffered one-hot write side of an 8-entry register file; `define REGFILE_R0_ZERO_EN hardwires r0 to zero
module regfile_wr_demux #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               flush,
    output logic [8*WIDTH-1:0] regs_flat,
    output logic [7:0]         wr_en_onehot,
    output logic [7:0]         pending_mask,
    output logic               busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef REGFILE_R0_ZERO_EN
    localparam logic [7:0] WMASK = 8'hFE;
`else
    localparam logic [7:0] WMASK = 8'hFF;
`endif
    typedef enum logic {EMPTY, DRAIN} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [2:0] baddr_q[DEPTH], baddr_d[DEPTH];
    logic [WIDTH-1:0] bdata_q[DEPTH], bdata_d[DEPTH];
    logic [WIDTH-1:0] regs_q[8], regs_d[8];
    logic [7:0] wr_en_q, wr_en_d;
    logic push, pop;
    int idx;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ready = (count_q < CW'(DEPTH)) && !flush;
        push = wr_valid && wr_ready;
        pop = (count_q != '0) && !flush;
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
        head_d = flush ? '0 : pop ? inc(head_q) : head_q;
        tail_d = flush ? '0 : push ? inc(tail_q) : tail_q;
        baddr_d = baddr_q;
        bdata_d = bdata_q;
        if (push) begin
            baddr_d[tail_q] = wr_addr;
            bdata_d[tail_q] = wr_data;
        end
        wr_en_d = pop ? ((8'b1 << baddr_q[head_q]) & WMASK) : '0;
        regs_d = regs_q;
        for (int i = 0; i < 8; i++)
            if (wr_en_d[i]) regs_d[i] = bdata_q[head_q];
        state_d = flush ? EMPTY
                : state_q == EMPTY ? (push ? DRAIN : EMPTY)
                : (pop && count_q == CW'(1) && !push) ? EMPTY : DRAIN;
        // Walk the live entries from head, wrapping modulo DEPTH.
        pending_mask = '0;
        idx = 0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = int'(head_q) + k;
            if (idx >= DEPTH) idx = idx - DEPTH;
            if (CW'(k) < count_q) pending_mask = pending_mask | (8'b1 << baddr_q[PW'(idx)]);
        end
        pending_mask = pending_mask & WMASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            baddr_q <= '{default: '0};
            bdata_q <= '{default: '0};
            regs_q  <= '{default: '0};
            wr_en_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            baddr_q <= baddr_d;
            bdata_q <= bdata_d;
            regs_q  <= regs_d;
            wr_en_q <= wr_en_d;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
    end
    assign wr_en_onehot = wr_en_q;
    assign busy = state_q == DRAIN;
endmodule

// File: doc/regfile_wr_demux.md
Name: regfile_wr_demux

Overview:
- Write side of the processor's 8-entry register file: accepts writeback requests (3-bit destination, data) and routes each to exactly one register via a registered one-hot decode.
- Buffers up to DEPTH requests so the multicycle control FSM can issue a writeback without stalling on commit.
- Exposes all register contents flat for the read-side selectors, plus a pending-destination mask for hazard checks.

Parameters:
- WIDTH, 16, data width of each register and of wr_data.
- DEPTH, 2, writeback buffer entries (legal values 1..4).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  writeback request present.
- wr_ready  out  1  block can accept a request this cycle.
- wr_addr  in  3  destination register index 0..7.
- wr_data  in  WIDTH  value to write.
- flush  in  1  discard all queued, uncommitted requests.
- regs_flat  out  8*WIDTH  register i occupies bits [i*WIDTH +: WIDTH].
- wr_en_onehot  out  8  one-hot strobe of the register committed in the previous cycle.
- pending_mask  out  8  bit i set while any queued, uncommitted entry targets register i.
- busy  out  1  buffer non-empty.

Behaviour:
- Reset, synchronous, active-high:
  - all registers, buffer, count, pointers and wr_en_onehot go to 0.
  - wr_ready = 1 in the cycle after reset deasserts; busy = 0; pending_mask = 0.
  - Reset asserted mid-operation discards queued entries; no commit happens on that edge.
- Accept: on an edge where wr_valid && wr_ready, {wr_addr, wr_data} is pushed at the tail.
- wr_ready = (count < DEPTH) && !flush. This is combinational from registered count plus flush; it does not depend on wr_valid.
- Commit:
  - On every edge with count > 0 and !flush, the head entry is written to register wr_addr and popped.
  - At most one commit per cycle.
- Latency: a request accepted at edge k into an empty buffer commits at edge k+1. It is visible on regs_flat and wr_en_onehot after edge k+1.
- wr_en_onehot is registered. It is 1<<addr for the cycle after a commit edge and 0 otherwise; never more than one bit set.
- Simultaneous accept and commit: push and pop on the same edge, count unchanged. When full, wr_ready = 0, so no accept occurs even if a commit frees a slot that edge.
- Flush:
  - On a flush edge, count and pointers clear and no commit occurs.
  - wr_ready is low during flush, so no accept occurs.
  - Registers are unchanged.
- Same destination queued twice: entries commit in order, so the last write wins.
- pending_mask:
  - Combinational OR of one-hot(addr) over valid buffer entries.
  - Bits clear in the cycle after their last entry commits.
- busy = (count != 0).
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH+1).
- Control is a two-state FSM:
  - EMPTY → DRAIN on accept.
  - DRAIN → EMPTY when a pop leaves count 0 with no simultaneous push.
  - Any state → EMPTY on flush or reset.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0; a request to address 0 is still accepted and popped, but the register is not written.
  - wr_en_onehot[0] and pending_mask[0] are always 0.
- Undefined: register 0 is an ordinary writable register.

Test Plan:
- Reset, then a single write: wr_addr=3, wr_data=16'hBEEF at edge k → after edge k+1, regs_flat[63:48]=16'hBEEF and wr_en_onehot=8'b0000_1000 for one cycle; busy low again.
- Back-to-back valid on every cycle, DEPTH=2: writes to r1..r7 with data 16'h0011..16'h0077 → all registers correct; at most one commit per cycle; wr_ready never deasserts, since push and pop balance.
- Stall fill with commits blocked by flush: hold flush=0 and push 3 requests in consecutive cycles into an empty buffer with DEPTH=1 → wr_ready=0 on the cycle after the first accept; the second request is accepted only after the first commits; order is preserved.
- Ordering to the same destination: queue r5=16'h1111 then r5=16'h2222 → final r5=16'h2222; pending_mask[5] stays set until the second commit, then clears.
- Flush: queue r2 and r4, then assert flush on the next edge → r4 is never written; pending_mask=0 and busy=0 after the flush; r2 is committed only if it popped before the flush edge.
- REGFILE_R0_ZERO_EN:
  - Defined: write r0=16'hFFFF → regs_flat[15:0] stays 0 and wr_en_onehot stays 0.
  - Undefined: regs_flat[15:0]=16'hFFFF.
